// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, funct3 codes, FSM states and the
// request decode helpers.
package load_store_unit_pkg;

  localparam logic [1:0] MemAccessByte = 2'b00;
  localparam logic [1:0] MemAccessHalf = 2'b01;
  localparam logic [1:0] MemAccessWord = 2'b10;

  localparam logic [2:0] LsuF3Lb  = 3'b000;
  localparam logic [2:0] LsuF3Lh  = 3'b001;
  localparam logic [2:0] LsuF3Lw  = 3'b010;
  localparam logic [2:0] LsuF3Lbu = 3'b100;
  localparam logic [2:0] LsuF3Lhu = 3'b101;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLdAddr   = 3'd1,
    StLdData   = 3'd2,
    StStIssue  = 3'd3,
    StStCommit = 3'd4,
    StResp     = 3'd5,
    StFault    = 3'd6
  } lsu_state_e;

  // Stores only support the signed-looking codes; unsigned variants are load-only.
  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    logic legal;
    legal = (f3 == LsuF3Lb) || (f3 == LsuF3Lh) || (f3 == LsuF3Lw);
    if (!store) begin
      legal = legal || (f3 == LsuF3Lbu) || (f3 == LsuF3Lhu);
    end
    return !legal;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lsb);
    logic mis;
    unique case (f3[1:0])
      MemAccessHalf: mis = addr_lsb[0];
      MemAccessWord: mis = (addr_lsb != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Core-side front end for the memory controller: validates one request at a time, sequences
// the controller's read/write ports and returns a one-cycle response to writeback.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [4:0]  rsp_rd_o,
  output logic        rsp_misaligned_o,
  output logic        rsp_illegal_o,
  output logic [1:0]  mem_acc_r_o,
  output logic [31:0] mem_addr_r_o,
  input  logic [31:0] mem_data_r_i,
  output logic        mem_wr_en_o,
  output logic [1:0]  mem_acc_w_o,
  output logic [31:0] mem_addr_w_o,
  output logic [31:0] mem_data_w_o,
  input  logic        mem_wr_ready_i
);

  lsu_state_e  state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;

  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic [4:0]  rsp_rd_q;
  logic        rsp_mis_q;
  logic        rsp_ill_q;

  logic        handshake;
  logic        req_ill;
  logic        req_mis;
  logic [31:0] ld_data_d;

  assign req_ready_o = (state_q == StIdle);
  assign handshake   = req_valid_i && req_ready_o;
  // Illegal wins, so misaligned is only reported for otherwise legal requests.
  assign req_ill     = f3_illegal(req_store_i, req_funct3_i);
  assign req_mis     = !req_ill && misaligned(req_funct3_i, req_addr_i[1:0]);

  // The controller always sign-extends; undo that for the unsigned loads.
  always_comb begin
    ld_data_d = mem_data_r_i;
    if (funct3_q == LsuF3Lbu) begin
      ld_data_d = {24'h0, mem_data_r_i[7:0]};
    end else if (funct3_q == LsuF3Lhu) begin
      ld_data_d = {16'h0, mem_data_r_i[15:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      rsp_mis_q   <= 1'b0;
      rsp_ill_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      rsp_mis_q   <= 1'b0;
      rsp_ill_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (handshake) begin
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            funct3_q <= req_funct3_i;
            rd_q     <= req_rd_i;
            if (req_ill || req_mis) begin
              state_q     <= StFault;
              rsp_valid_q <= 1'b1;
              rsp_rd_q    <= req_rd_i;
              rsp_mis_q   <= req_mis;
              rsp_ill_q   <= req_ill;
            end else if (req_store_i) begin
              state_q <= StStIssue;
            end else begin
              state_q <= StLdAddr;
            end
          end
        end
        StLdAddr: state_q <= StLdData;
        StLdData: begin
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= ld_data_d;
          rsp_rd_q    <= rd_q;
        end
        StStIssue: begin
          if (mem_wr_ready_i) begin
            state_q <= StStCommit;
          end
        end
        StStCommit: begin
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
          rsp_rd_q    <= rd_q;
        end
        StResp, StFault: state_q <= StIdle;
        default:         state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_rdata_o      = rsp_rdata_q;
  assign rsp_rd_o         = rsp_rd_q;
  assign rsp_misaligned_o = rsp_mis_q;
  assign rsp_illegal_o    = rsp_ill_q;

  // Operands stay on the ports for the cycle after the address too, since the controller's
  // read data and write merge both depend on them then.
  always_comb begin
    mem_acc_r_o  = MemAccessWord;
    mem_addr_r_o = '0;
    mem_wr_en_o  = 1'b0;
    mem_acc_w_o  = MemAccessWord;
    mem_addr_w_o = '0;
    mem_data_w_o = '0;
    unique case (state_q)
      StLdAddr, StLdData: begin
        mem_acc_r_o  = funct3_q[1:0];
        mem_addr_r_o = addr_q;
      end
      StStIssue, StStCommit: begin
        mem_wr_en_o  = (state_q == StStIssue) && mem_wr_ready_i;
        mem_acc_w_o  = funct3_q[1:0];
        mem_addr_w_o = addr_q;
        mem_data_w_o = wdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-addressed controller model.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_store_i = 1'b0;
  logic [2:0]  req_funct3_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [4:0]  rsp_rd_o;
  logic        rsp_misaligned_o;
  logic        rsp_illegal_o;
  logic [1:0]  mem_acc_r_o;
  logic [31:0] mem_addr_r_o;
  logic [31:0] mem_data_r_i = '0;
  logic        mem_wr_en_o;
  logic [1:0]  mem_acc_w_o;
  logic [31:0] mem_addr_w_o;
  logic [31:0] mem_data_w_o;
  logic        mem_wr_ready_i = 1'b1;

  load_store_unit dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_store_i     (req_store_i),
    .req_funct3_i    (req_funct3_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .req_rd_i        (req_rd_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_rdata_o     (rsp_rdata_o),
    .rsp_rd_o        (rsp_rd_o),
    .rsp_misaligned_o(rsp_misaligned_o),
    .rsp_illegal_o   (rsp_illegal_o),
    .mem_acc_r_o     (mem_acc_r_o),
    .mem_addr_r_o    (mem_addr_r_o),
    .mem_data_r_i    (mem_data_r_i),
    .mem_wr_en_o     (mem_wr_en_o),
    .mem_acc_w_o     (mem_acc_w_o),
    .mem_addr_w_o    (mem_addr_w_o),
    .mem_data_w_o    (mem_data_w_o),
    .mem_wr_ready_i  (mem_wr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        mis;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          wr_en_count = 0;
  logic [7:0]  mem[int unsigned];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input int unsigned a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Controller model: sign-extended read data one cycle after the address, byte-lane writes.
  always @(posedge clk_i) begin
    logic [31:0] a;
    cyc <= cyc + 1;
    a = mem_addr_r_o;
    case (mem_acc_r_o)
      2'b00:   mem_data_r_i <= {{24{rd_byte(a)[7]}}, rd_byte(a)};
      2'b01:   mem_data_r_i <= {{16{rd_byte(a + 1)[7]}}, rd_byte(a + 1), rd_byte(a)};
      default: mem_data_r_i <= {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
    endcase
    if (mem_wr_en_o) begin
      wr_en_count <= wr_en_count + 1;
      mem[mem_addr_w_o] = mem_data_w_o[7:0];
      if (mem_acc_w_o != 2'b00) mem[mem_addr_w_o + 1] = mem_data_w_o[15:8];
      if (mem_acc_w_o == 2'b10) begin
        mem[mem_addr_w_o + 2] = mem_data_w_o[23:16];
        mem[mem_addr_w_o + 3] = mem_data_w_o[31:24];
      end
    end
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (rstn_i && rsp_valid_o) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_rsp", {31'h0, rsp_valid_o}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check_eq("rsp_rdata", rsp_rdata_o, e.rdata);
        check_eq("rsp_rd", {27'h0, rsp_rd_o}, {27'h0, e.rd});
        check_eq("rsp_misaligned", {31'h0, rsp_misaligned_o}, {31'h0, e.mis});
        check_eq("rsp_illegal", {31'h0, rsp_illegal_o}, {31'h0, e.ill});
        check_eq("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // lat: 3 for completed accesses, 1 for faults; extra: cycles ST_ISSUE waits on ready.
  task automatic do_req(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] exp_rdata, input logic exp_mis, input logic exp_ill,
                        input int lat, input int extra, input bit push);
    int   n;
    int   waited = 0;
    exp_t e;
    @(negedge clk_i);
    while (!req_ready_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    if (!req_ready_o) begin
      check_eq("req_ready_timeout", {31'h0, req_ready_o}, 32'h1);
      return;
    end
    req_valid_i  = 1'b1;
    req_store_i  = store;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_rd_i     = rd;
    n = cyc + 1;
    if (push) begin
      e.rdata = exp_rdata;
      e.rd    = rd;
      e.mis   = exp_mis;
      e.ill   = exp_ill;
      e.cyc   = n + lat - 1 + extra;
      sb_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  initial begin
    int wait_cnt;
    mem[32'h100] = 8'hBB;
    mem[32'h101] = 8'hAA;
    mem[32'h102] = 8'h99;
    mem[32'h103] = 8'h88;

    #2;
    check_eq("reset_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    check_eq("reset_rsp_rdata", rsp_rdata_o, 32'h0);
    check_eq("reset_mem_acc_r", {30'h0, mem_acc_r_o}, 32'h2);
    check_eq("reset_mem_acc_w", {30'h0, mem_acc_w_o}, 32'h2);
    check_eq("reset_mem_wr_en", {31'h0, mem_wr_en_o}, 32'h0);
    check_eq("reset_mem_addr_r", mem_addr_r_o, 32'h0);
    #20;
    rstn_i = 1'b1;

    do_req(0, 3'b000, 32'h101, 0, 5'd1, 32'hFFFFFFAA, 0, 0, 3, 0, 1);  // LB
    do_req(0, 3'b100, 32'h101, 0, 5'd2, 32'h000000AA, 0, 0, 3, 0, 1);  // LBU
    do_req(0, 3'b001, 32'h102, 0, 5'd3, 32'hFFFF8899, 0, 0, 3, 0, 1);  // LH
    do_req(0, 3'b101, 32'h102, 0, 5'd4, 32'h00008899, 0, 0, 3, 0, 1);  // LHU
    do_req(0, 3'b010, 32'h100, 0, 5'd5, 32'h8899AABB, 0, 0, 3, 0, 1);  // LW
    do_req(1, 3'b010, 32'h104, 32'h12345678, 5'd6, 0, 0, 0, 3, 0, 1);  // SW
    do_req(1, 3'b000, 32'h105, 32'h000000EE, 5'd7, 0, 0, 0, 3, 0, 1);  // SB
    do_req(0, 3'b010, 32'h104, 0, 5'd8, 32'h1234EE78, 0, 0, 3, 0, 1);
    do_req(1, 3'b001, 32'h106, 32'h0000ABCD, 5'd9, 0, 0, 0, 3, 0, 1);  // SH
    do_req(0, 3'b010, 32'h104, 0, 5'd10, 32'hABCDEE78, 0, 0, 3, 0, 1);
    do_req(0, 3'b010, 32'h102, 0, 5'd11, 0, 1, 0, 1, 0, 1);            // misaligned LW
    do_req(0, 3'b001, 32'h101, 0, 5'd12, 0, 1, 0, 1, 0, 1);            // misaligned LH
    do_req(0, 3'b011, 32'h100, 0, 5'd13, 0, 0, 1, 1, 0, 1);            // illegal load
    do_req(0, 3'b011, 32'h101, 0, 5'd14, 0, 0, 1, 1, 0, 1);            // illegal beats misaligned
    do_req(1, 3'b100, 32'h100, 32'hDEAD, 5'd15, 0, 0, 1, 1, 0, 1);     // illegal store
    do_req(1, 3'b010, 32'h10A, 32'hDEAD, 5'd16, 0, 1, 0, 1, 0, 1);     // misaligned store

    // Store held off by the controller for three cycles.
    mem_wr_ready_i = 1'b0;
    do_req(1, 3'b010, 32'h108, 32'hCAFEF00D, 5'd17, 0, 0, 0, 3, 3, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("wait_req_ready", {31'h0, req_ready_o}, 32'h0);
      check_eq("wait_wr_en", {31'h0, mem_wr_en_o}, 32'h0);
    end
    @(negedge clk_i);
    mem_wr_ready_i = 1'b1;
    #1;
    check_eq("ready_wr_en", {31'h0, mem_wr_en_o}, 32'h1);
    check_eq("ready_addr_w", mem_addr_w_o, 32'h108);
    @(negedge clk_i);
    check_eq("commit_wr_en", {31'h0, mem_wr_en_o}, 32'h0);
    check_eq("commit_data_w", mem_data_w_o, 32'hCAFEF00D);
    do_req(0, 3'b010, 32'h108, 0, 5'd18, 32'hCAFEF00D, 0, 0, 3, 0, 1);

    // Reset while in LD_DATA: nothing may come back for this request.
    do_req(0, 3'b010, 32'h100, 0, 5'd19, 0, 0, 0, 3, 0, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("lddata_addr_r", mem_addr_r_o, 32'h100);
    rstn_i = 1'b0;
    #1;
    check_eq("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    check_eq("rst_mem_addr_r", mem_addr_r_o, 32'h0);
    check_eq("rst_mem_acc_r", {30'h0, mem_acc_r_o}, 32'h2);
    check_eq("rst_req_ready", {31'h0, req_ready_o}, 32'h1);
    repeat (3) @(negedge clk_i);
    check_eq("rst_hold_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    rstn_i = 1'b1;
    do_req(0, 3'b001, 32'h102, 0, 5'd20, 32'hFFFF8899, 0, 0, 3, 0, 1);

    wait_cnt = 0;
    while (sb_q.size() != 0 && wait_cnt < 50) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    check_eq("scoreboard_drained", sb_q.size(), 32'h0);
    check_eq("wr_en_pulses", wr_en_count, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
